// File: rtl/pht_update_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pht_update_ctrl : in-order read-modify-write controller for the PHT        |
// |   2-bit counters. Optional stats counters under PHT_UPD_STATS_EN.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pht_update_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int SET_W      = 2,
    parameter int IDX_W      = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic             res_taken,
    input  logic [SET_W-1:0] res_set,
    input  logic [IDX_W-1:0] res_idx,
    output logic             pht_wr_en,
    output logic [1:0]       pht_up_data,
    output logic [SET_W-1:0] pht_set_addr,
    output logic [IDX_W-1:0] pht_tab_addr,
    input  logic [1:0]       pht_rd_data,
    output logic             busy
`ifdef PHT_UPD_STATS_EN
    ,
    output logic [15:0]      stat_updates,
    output logic [15:0]      stat_sat
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_fifo_taken [FIFO_DEPTH];
    logic [SET_W-1:0]   r_fifo_set   [FIFO_DEPTH];
    logic [IDX_W-1:0]   r_fifo_idx   [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic               r_cur_taken;

    logic               w_push;
    logic               w_pop;
    logic [PTR_W-1:0]   w_head_nxt;

    function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic tk);
        if (tk)
            return (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
        else
            return (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
    endfunction

    assign res_ready  = (r_count != CNT_W'(FIFO_DEPTH));
    assign busy       = (r_count != '0) || (r_state != S_IDLE);
    assign w_push     = res_valid && res_ready;
    assign w_pop      = (r_state == S_WRITE);
    assign w_head_nxt = r_head + PTR_W'(1);

    // Entry storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_taken[r_tail] <= res_taken;
            r_fifo_set[r_tail]   <= res_set;
            r_fifo_idx[r_tail]   <= res_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_tail <= r_tail + PTR_W'(1);
            if (w_pop)
                r_head <= w_head_nxt;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            pht_wr_en    <= 1'b0;
            pht_up_data  <= 2'b00;
            pht_set_addr <= '0;
            pht_tab_addr <= '0;
            r_cur_taken  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    pht_wr_en <= 1'b0;
                    if (r_count != '0) begin
                        r_state      <= S_READ;
                        pht_set_addr <= r_fifo_set[r_head];
                        pht_tab_addr <= r_fifo_idx[r_head];
                        r_cur_taken  <= r_fifo_taken[r_head];
                    end
                end
                S_READ: begin
                    // Table read is combinational on the held address; the new value is registered here.
                    pht_up_data <= sat_next(pht_rd_data, r_cur_taken);
                    pht_wr_en   <= 1'b1;
                    r_state     <= S_WRITE;
                end
                S_WRITE: begin
                    pht_wr_en <= 1'b0;
                    if (r_count > CNT_W'(1)) begin
                        r_state      <= S_READ;
                        pht_set_addr <= r_fifo_set[w_head_nxt];
                        pht_tab_addr <= r_fifo_idx[w_head_nxt];
                        r_cur_taken  <= r_fifo_taken[w_head_nxt];
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    pht_wr_en <= 1'b0;
                end
            endcase
        end
    end

`ifdef PHT_UPD_STATS_EN
    logic [1:0] r_cur_cnt;
    logic       w_sat;

    assign w_sat = (r_cur_taken && (r_cur_cnt == 2'b11)) ||
                   (!r_cur_taken && (r_cur_cnt == 2'b00));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur_cnt    <= 2'b00;
            stat_updates <= 16'd0;
            stat_sat     <= 16'd0;
        end else begin
            if (r_state == S_READ)
                r_cur_cnt <= pht_rd_data;
            if (r_state == S_WRITE) begin
                stat_updates <= stat_updates + 16'd1;
                if (w_sat)
                    stat_sat <= stat_sat + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
